// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: splits a 32-bit MEM-stage load/store into two sequential
// 16-bit SRAM accesses (low half, then high half) and stalls the pipeline
// through `ready` until the word is complete.
// Optional feature macro: SRAM_LAST_READ_CACHE_EN keeps the last read word so
// a repeated load of the same word skips the SRAM entirely.
module sram_word_ctrl #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Count value of the final cycle of each half-word phase.
    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] wa;
    logic        last;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        unused_wa_hi;

`ifdef SRAM_LAST_READ_CACHE_EN
    logic        cache_vld_q, cache_vld_d;
    logic [16:0] cache_wa_q, cache_wa_d;
    logic [31:0] cache_data_q, cache_data_d;
    logic        cache_hit;

    // Match on the 17 bits that actually select an SRAM word, so aliased
    // addresses that wrap onto the same location are treated as the same word.
    assign cache_hit = cache_vld_q && (cache_wa_q == wa[16:0]);
`endif

    // Word address relative to the data-memory base; upper bits wrap away.
    assign wa           = (address - ADDR_BASE) >> 2;
    assign unused_wa_hi = ^wa[31:17];
    assign last         = (cnt_q == LAST_CNT);

    assign readData  = rdata_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;

    // Next-state, phase counter, read-data capture and cache update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
`ifdef SRAM_LAST_READ_CACHE_EN
        cache_vld_d  = cache_vld_q;
        cache_wa_d   = cache_wa_q;
        cache_data_d = cache_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (wr_en | rd_en) begin
                    is_wr_d = wr_en;
                    cnt_d   = 3'd0;
                    state_d = S_LO;
`ifdef SRAM_LAST_READ_CACHE_EN
                    if (!wr_en && cache_hit) begin
                        state_d = S_DONE;
                        rdata_d = cache_data_q;
                    end
`endif
                end
            end
            S_LO: begin
                if (last) begin
                    cnt_d   = 3'd0;
                    state_d = S_HI;
                    if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_HI: begin
                if (last) begin
                    cnt_d   = 3'd0;
                    state_d = S_DONE;
                    if (!is_wr_q) begin
                        rdata_d[31:16] = SRAM_DQ;
`ifdef SRAM_LAST_READ_CACHE_EN
                        cache_vld_d  = 1'b1;
                        cache_wa_d   = wa[16:0];
                        cache_data_d = {SRAM_DQ, rdata_q[15:0]};
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                // DONE: the pipeline advances on this edge; requests are ignored.
                state_d = S_IDLE;
`ifdef SRAM_LAST_READ_CACHE_EN
                if (is_wr_q && cache_hit) cache_data_d = writeData;
`endif
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            is_wr_q <= 1'b0;
            rdata_q <= 32'd0;
`ifdef SRAM_LAST_READ_CACHE_EN
            cache_vld_q  <= 1'b0;
            cache_wa_q   <= 17'd0;
            cache_data_q <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
`ifdef SRAM_LAST_READ_CACHE_EN
            cache_vld_q  <= cache_vld_d;
            cache_wa_q   <= cache_wa_d;
            cache_data_q <= cache_data_d;
`endif
        end
    end

    // SRAM pin drive: active only during LO/HI; WE_N lifts on the final
    // cycle of a write phase so data is held past the write strobe.
    always_comb begin
        SRAM_ADDR = 18'd0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = 16'd0;
        if (state_q == S_LO || state_q == S_HI) begin
            SRAM_ADDR = {wa[16:0], (state_q == S_HI)};
            if (is_wr_q) begin
                dq_oe     = 1'b1;
                dq_out    = (state_q == S_HI) ? writeData[31:16] : writeData[15:0];
                SRAM_WE_N = last;
            end else begin
                SRAM_OE_N = 1'b0;
            end
        end
    end

    // Stall output: low while a request is pending or in flight.
    always_comb begin
        ready = 1'b1;
        if (rst) begin
            case (state_q)
                S_IDLE:  ready = ~(wr_en | rd_en);
                S_DONE:  ready = 1'b1;
                default: ready = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Directed bench for sram_word_ctrl with a behavioural 16-bit SRAM model.
module tb_sram_word_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, writeData;
    logic [31:0] readData;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:262143];

    always #5 clk = ~clk;

    sram_word_ctrl #(.WAIT_CYCLES(1), .ADDR_BASE(32'd1024)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .writeData(writeData), .readData(readData),
        .ready(ready), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    // SRAM model: drives the bus on reads, latches data while WE_N is low.
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'bz;
    always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr] <= sram_dq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr, rd;
        logic [31:0] addr, wdata, exp_rdata;
        logic [17:0] exp_lo, exp_hi;
        int          exp_low, exp_oe, exp_we;
    } vec_t;

    // Issue one request and observe it until ready returns (DONE or hit).
    task automatic run_txn(input logic wr, input logic rd, input logic [31:0] a,
                           input logic [31:0] wd, output int low, output int oe,
                           output int we, output logic [17:0] lo_a,
                           output logic [17:0] hi_a, output logic [31:0] rdat);
        low = 0; oe = 0; we = 0; lo_a = '0; hi_a = '0;
        @(negedge clk);
        wr_en = wr; rd_en = rd; address = a; writeData = wd;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (ready) break;
            if (i == 1) lo_a = sram_addr;
            hi_a = sram_addr;
            low++;
            if (!oe_n) oe++;
            if (!we_n) we++;
            @(negedge clk); #1;
        end
        if (!ready) begin
            checks++; failures++;
            $display("FAIL timeout: ready still low after 40 cycles");
        end
        rdat = readData;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    vec_t        vecs [8];
    int          low, oe, we;
    logic [17:0] lo_a, hi_a;
    logic [31:0] rdat;

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
        vecs[0] = '{1'b1, 1'b0, 32'd1024,    32'hDEADBEEF, 32'h00000000, 18'h00000, 18'h00001, 5, 0, 2};
        vecs[1] = '{1'b0, 1'b1, 32'd1024,    32'h0,        32'hDEADBEEF, 18'h00000, 18'h00001, 5, 4, 0};
        vecs[2] = '{1'b1, 1'b1, 32'd1028,    32'h12345678, 32'hDEADBEEF, 18'h00002, 18'h00003, 5, 0, 2};
        vecs[3] = '{1'b1, 1'b0, 32'd1020,    32'hCAFEF00D, 32'hDEADBEEF, 18'h3FFFE, 18'h3FFFF, 5, 0, 2};
        vecs[4] = '{1'b0, 1'b1, 32'd1020,    32'h0,        32'hCAFEF00D, 18'h3FFFE, 18'h3FFFF, 5, 4, 0};
        vecs[5] = '{1'b0, 1'b1, 32'd1028,    32'h0,        32'h12345678, 18'h00002, 18'h00003, 5, 4, 0};
        vecs[6] = '{1'b1, 1'b0, 32'h00080400, 32'h11112222, 32'h12345678, 18'h00000, 18'h00001, 5, 0, 2};
        vecs[7] = '{1'b0, 1'b1, 32'd1024,    32'h0,        32'h11112222, 18'h00000, 18'h00001, 5, 4, 0};

        // Reset with a request pending: ready must still read high.
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b1; address = 32'd1024; writeData = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_rdata", readData, 32'd0);
        chk("rst_we_n", {31'd0, we_n}, 32'd1);
        chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
        chk("rst_addr", {14'd0, sram_addr}, 32'd0);
        chk("const_pins", {28'd0, ub_n, lb_n, ce_n, 1'b0}, 32'd0);
        rd_en = 1'b0; rst = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].wdata,
                    low, oe, we, lo_a, hi_a, rdat);
            chk($sformatf("v%0d_low", v), low, vecs[v].exp_low);
            chk($sformatf("v%0d_oe", v), oe, vecs[v].exp_oe);
            chk($sformatf("v%0d_we", v), we, vecs[v].exp_we);
            chk($sformatf("v%0d_lo_addr", v), {14'd0, lo_a}, {14'd0, vecs[v].exp_lo});
            chk($sformatf("v%0d_hi_addr", v), {14'd0, hi_a}, {14'd0, vecs[v].exp_hi});
            chk($sformatf("v%0d_rdata", v), rdat, vecs[v].exp_rdata);
            if (vecs[v].wr) begin
                chk($sformatf("v%0d_mem_lo", v), {16'd0, mem[vecs[v].exp_lo]}, {16'd0, vecs[v].wdata[15:0]});
                chk($sformatf("v%0d_mem_hi", v), {16'd0, mem[vecs[v].exp_hi]}, {16'd0, vecs[v].wdata[31:16]});
            end
        end

`ifdef SRAM_LAST_READ_CACHE_EN
        // Word 0 was just read: a repeat load hits without touching the SRAM.
        run_txn(1'b0, 1'b1, 32'd1024, 32'h0, low, oe, we, lo_a, hi_a, rdat);
        chk("hit_low", low, 1);
        chk("hit_oe", oe, 0);
        chk("hit_rdata", rdat, 32'h11112222);
        run_txn(1'b1, 1'b0, 32'd1024, 32'h0, low, oe, we, lo_a, hi_a, rdat);
        chk("hitwr_low", low, 5);
        chk("hitwr_mem", {mem[1], mem[0]}, 32'h0);
        run_txn(1'b0, 1'b1, 32'd1024, 32'h0, low, oe, we, lo_a, hi_a, rdat);
        chk("hit2_low", low, 1);
        chk("hit2_rdata", rdat, 32'h0);
`endif

        // Reset in the middle of the HI phase of a write.
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1024; writeData = 32'hAAAA5555;
        repeat (3) @(negedge clk);
        chk("mid_hi_we_n", {31'd0, we_n}, 32'd0);
        chk("mid_hi_addr", {14'd0, sram_addr}, 32'd1);
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("mrst_we_n", {31'd0, we_n}, 32'd1);
        chk("mrst_oe_n", {31'd0, oe_n}, 32'd1);
        chk("mrst_addr", {14'd0, sram_addr}, 32'd0);
        chk("mrst_rdata", readData, 32'd0);
        rst = 1'b1; #1;
        chk("mrst_ready", {31'd0, ready}, 32'd1);

        // Controller resumes normally after the abandoned write.
        run_txn(1'b0, 1'b1, 32'd1020, 32'h0, low, oe, we, lo_a, hi_a, rdat);
        chk("post_rst_low", low, 5);
        chk("post_rst_rdata", rdat, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_word_ctrl.md
# sram_word_ctrl

Word-access controller between the MEM stage and the external 16-bit SRAM. It takes the MEM stage's 32-bit load/store request and performs two sequential half-word SRAM accesses per word: low half first, then high half. It holds `ready` low until the word is complete, so the pipeline freezes for the duration. It returns the assembled 32-bit load value to the MEM stage.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: extra cycles each half-word access is held on the pins (0–7).
- `ADDR_BASE`, default 1024: data-memory base byte address, subtracted before mapping.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `wr_en` in 1: store request from the MEM stage.
- `rd_en` in 1: load request from the MEM stage.
- `address` in 32: byte address (ALU result).
- `writeData` in 32: store value.
- `readData` out 32: load value, registered.
- `ready` out 1: high = request complete or none pending.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_UB_N`, `SRAM_LB_N` out 1: byte masks, constant 0.
- `SRAM_WE_N` out 1: write enable, active-low.
- `SRAM_CE_N` out 1: chip enable, constant 0.
- `SRAM_OE_N` out 1: output enable, active-low.

## Operation
- Address mapping: `wa = (address - ADDR_BASE) >> 2`, computed in 32-bit arithmetic.
  - Low half goes to `SRAM_ADDR = {wa[16:0],1'b0}`; high half goes to `{wa[16:0],1'b1}`.
  - Upper bits are truncated, so wrap-around is modulo 2^18 with no error.
  - Addresses below `ADDR_BASE` also wrap.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - `wr_en|rd_en` → LO, with the operation latched as write if `wr_en`; write has priority when both are set.
  - Otherwise stay in IDLE.
- LO: held `WAIT_CYCLES+1` cycles (counter `cnt`), then → HI.
- HI: held `WAIT_CYCLES+1` cycles, then → DONE.
- DONE: one cycle, then → IDLE unconditionally. Requests seen in DONE are ignored, because the pipeline advances on this edge.
- `ready`:
  - In IDLE, `ready = ~(wr_en|rd_en)`.
  - In DONE, `ready = 1`.
  - In LO and HI, `ready = 0`.
  - `ready` is combinational from state and inputs.
- Pipeline inputs (`address`, `writeData`, enables) are held stable by the pipeline while `ready=0`. The controller samples them directly and does not latch them, except for the operation type.
- Write in LO/HI:
  - `SRAM_DQ` is driven with `writeData[15:0]` in LO and `writeData[31:16]` in HI.
  - `SRAM_WE_N=0` in every cycle of the phase except the last, where it returns to 1 while data is still driven (hold).
  - `SRAM_OE_N=1`.
- Read in LO/HI:
  - `SRAM_DQ` is high-Z and `SRAM_OE_N=0`.
  - On the last cycle of LO, `SRAM_DQ` is captured into `readData[15:0]`; on the last cycle of HI, into `readData[31:16]`.
- Outside LO/HI: `SRAM_DQ` high-Z, `WE_N=1`, `OE_N=1`, `SRAM_ADDR=0`.
- `readData` holds its value until the next read overwrites it. Writes never change `readData`.

## Timing
- Reset values (rst=0 at an edge):
  - state=IDLE, `cnt=0`, `readData=0`.
  - `SRAM_WE_N=1`, `SRAM_OE_N=1`, `SRAM_ADDR=0`, `SRAM_DQ` high-Z.
  - `ready=1` while rst=0.
- Access latency, request first seen in IDLE at cycle 0:
  - `ready` is low for cycles 0 … 2·(WAIT_CYCLES+1).
  - `ready` is high in cycle 2·(WAIT_CYCLES+1)+1 (DONE).
  - With the default of 1, that is 5 low cycles and `ready` high in cycle 5.
- `readData` is valid from the DONE cycle onward.
- Reset mid-access: on the resetting edge, the FSM is forced to IDLE and `WE_N` is deasserted. The partial SRAM write is abandoned: half may be written. `readData` is cleared.

## Configuration
- `SRAM_LAST_READ_CACHE_EN` defined:
  - The controller keeps a valid bit, the word address `wa` of the last completed read, and its data.
  - A read whose `wa` matches a valid entry goes IDLE→DONE directly: `ready` is low 1 cycle, there is no SRAM activity, and `readData` is reloaded from the cache.
  - A write to a matching `wa` updates the cached data at DONE.
  - Reset clears the valid bit.
- Not defined: every read performs the full two-phase access; the cache logic is absent.

## Test plan
- Reset: hold rst=0 for 3 cycles → `readData=0`, `ready=1`, `WE_N=1`, `OE_N=1`, `DQ` high-Z.
- Store 0xDEADBEEF at address 1024, WAIT_CYCLES=1 → SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; `ready` low 5 cycles, then high 1 cycle.
- Load from 1024 after the store → `readData=0xDEADBEEF` in the DONE cycle; `OE_N` is low for exactly 4 cycles.
- `wr_en=rd_en=1` at address 1028 with data 0x12345678 → write performed, SRAM[2]=0x5678, SRAM[3]=0x1234; `readData` unchanged.
- Address 1020 (below base) → wraps to `SRAM_ADDR` 0x3FFFE/0x3FFFF; rst=0 asserted during HI of a write → next cycle IDLE, `WE_N=1`, `ready=1`.
- With `SRAM_LAST_READ_CACHE_EN`: two consecutive loads from 1024 → the second has `ready` low 1 cycle and the same data; a store of 0x0 to 1024 followed by a load → returns 0x00000000.
